// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pgate_seq_if.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__pgate_seq_if.sv - power-controller <-> switch sequencer signal bundle
//
// Signals:
//   PWR_REQ  level request from the power controller (1 = domain powered)
//   PWR_ACK  all segments on and isolation released
//   SW_EN    header-switch segment enables, thermometer code
//   ISO_EN   domain output isolation
//   BUSY     sequencer is ramping
// Modports:
//   master   power-controller side (drives PWR_REQ)
//   slave    sequencer side (drives everything else)
interface gf180mcu_fd_sc_mcu7t5v0__pgate_seq_if #(
    parameter int NSEG = 4
);
    logic            PWR_REQ;
    logic            PWR_ACK;
    logic [NSEG-1:0] SW_EN;
    logic            ISO_EN;
    logic            BUSY;

    modport master (
        output PWR_REQ,
        input  PWR_ACK,
        input  SW_EN,
        input  ISO_EN,
        input  BUSY
    );

    modport slave (
        input  PWR_REQ,
        output PWR_ACK,
        output SW_EN,
        output ISO_EN,
        output BUSY
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pgate_seq.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__pgate_seq.sv - staged power-gate switch and isolation sequencer
//
// Ports:
//   CLK  rising-edge clock
//   RN   asynchronous active-low reset
//   bus  slave side of the sequencer interface (PWR_REQ in; PWR_ACK, SW_EN,
//        ISO_EN, BUSY out, all registered)
//
// Segments come up one every STEP_CYC cycles (bit 0 first) and go down in
// reverse order. Power-up may be aborted; power-down always runs to OFF.
module gf180mcu_fd_sc_mcu7t5v0__pgate_seq #(
    parameter int NSEG     = 4,
    parameter int STEP_CYC = 8,
    parameter int CW       = 4
) (
    input  logic CLK,
    input  logic RN,
    gf180mcu_fd_sc_mcu7t5v0__pgate_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_OFF,
        S_UP,
        S_ON,
        S_ISO,
        S_DOWN
    } state_t;

    localparam logic [CW-1:0]   LAST = CW'(STEP_CYC - 1);
    localparam logic [NSEG-1:0] ONE  = NSEG'(1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NSEG-1:0] sw, sw_nxt;
    logic            iso, iso_nxt;
    logic            ack, ack_nxt;
    logic            busy, busy_nxt;

    // SW_EN is a thermometer code, so the top bit means every segment is on
    // and bit 0 means at least one is on.
    logic step_done, all_on, any_on;
    assign step_done = (cnt == LAST);
    assign all_on    = sw[NSEG-1];
    assign any_on    = sw[0];

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= S_OFF;
            cnt   <= '0;
            sw    <= '0;
            iso   <= 1'b1;
            ack   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sw    <= sw_nxt;
            iso   <= iso_nxt;
            ack   <= ack_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sw_nxt    = sw;
        iso_nxt   = iso;
        ack_nxt   = ack;
        busy_nxt  = busy;
        case (state)
            S_OFF: begin
                if (bus.PWR_REQ) begin
                    state_nxt = S_UP;
                    sw_nxt    = ONE;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            S_UP: begin
                if (!bus.PWR_REQ) begin
                    // Abort: start unwinding on this very edge; isolation never dropped.
                    state_nxt = S_DOWN;
                    sw_nxt    = sw >> 1;
                    cnt_nxt   = '0;
                end else if (step_done) begin
                    cnt_nxt = '0;
                    if (all_on) begin
                        state_nxt = S_ON;
                        iso_nxt   = 1'b0;
                        ack_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        sw_nxt = (sw << 1) | ONE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_ON: begin
                if (!bus.PWR_REQ) begin
                    state_nxt = S_ISO;
                    ack_nxt   = 1'b0;
                    iso_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            S_ISO: begin
                // One cycle of isolation before the first segment drops.
                state_nxt = S_DOWN;
                sw_nxt    = sw >> 1;
                cnt_nxt   = '0;
            end
            S_DOWN: begin
                if (step_done) begin
                    cnt_nxt = '0;
                    if (any_on) begin
                        sw_nxt = sw >> 1;
                    end else begin
                        state_nxt = S_OFF;
                        busy_nxt  = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_OFF;
                cnt_nxt   = '0;
                sw_nxt    = '0;
                iso_nxt   = 1'b1;
                ack_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.SW_EN   = sw;
    assign bus.ISO_EN  = iso;
    assign bus.PWR_ACK = ack;
    assign bus.BUSY    = busy;
endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__pgate_seq.md
Name: gf180mcu_fd_sc_mcu7t5v0__pgate_seq

Overview:
Power-gate switch sequencer. It drives the staged header-switch enables and the isolation control for a switchable rail domain. That domain is populated by passive rail-tied cells such as fills, decaps and taps. Segments turn on one at a time to limit inrush current, and turn off in reverse order. A 4-phase REQ/ACK handshake connects it to the power controller.

Parameters:
NSEG, 4, number of switch segments (>=1)
STEP_CYC, 8, clock cycles between consecutive segment transitions (>=1)
CW, 4, step counter width; must satisfy 2**CW >= STEP_CYC

Ports:
CLK  input  1  rising-edge clock
RN  input  1  asynchronous active-low reset
PWR_REQ  input  1  level request: 1 = domain powered, 0 = domain off
PWR_ACK  output  1  1 = all segments on and isolation released
SW_EN  output  NSEG  segment enables, thermometer code (bit 0 first on, last off)
ISO_EN  output  1  1 = domain outputs isolated
BUSY  output  1  1 while ramping (states UP, ISO, DOWN)

Behaviour:
- Reset: RN low asynchronously forces SW_EN=0, ISO_EN=1, PWR_ACK=0, BUSY=0, state=OFF, cnt=0. This holds mid-ramp (abrupt shutdown is accepted). Release is synchronous to the next CLK edge.
- All outputs are registered. PWR_REQ is sampled on rising CLK edges; there is no internal synchronizer.
- Invariant: SW_EN is always of the form 0..01..1. PWR_ACK=1 implies SW_EN all ones and ISO_EN=0.
- States are OFF, UP, ON, ISO, DOWN. cnt is the CW-bit step counter. nen is the number of enabled segments.
- OFF:
  - On sampling PWR_REQ=1 at edge E0: go to UP, SW_EN[0]=1, cnt=0, BUSY=1.
- UP:
  - cnt increments each cycle.
  - When cnt==STEP_CYC-1 and nen<NSEG: enable the next segment and set cnt=0.
  - When cnt==STEP_CYC-1 and nen==NSEG: go to ON, ISO_EN=0, PWR_ACK=1, BUSY=0.
  - Timing: segment k turns on at E0+k*STEP_CYC; PWR_ACK rises at E0+NSEG*STEP_CYC (32 cycles for the defaults).
- UP abort: PWR_REQ=0 sampled in UP goes to DOWN on that edge. The highest enabled segment turns off on the same edge and cnt=0. ISO_EN stays 1.
- ON:
  - Holds while PWR_REQ=1.
  - On sampling PWR_REQ=0 at edge D0: go to ISO, PWR_ACK=0, ISO_EN=1, BUSY=1, with SW_EN unchanged.
- ISO:
  - Lasts exactly one cycle.
  - At D0+1: turn off the highest segment, cnt=0, go to DOWN.
  - PWR_REQ is ignored here.
- DOWN:
  - When cnt==STEP_CYC-1 and nen>0: turn off the highest enabled segment and set cnt=0.
  - When cnt==STEP_CYC-1 and nen==0: go to OFF, BUSY=0.
  - Timing from ON: segment NSEG-1-k turns off at D0+1+k*STEP_CYC; OFF is reached at D0+1+NSEG*STEP_CYC (33 for the defaults).
- DOWN is not abortable. PWR_REQ=1 during DOWN is held off until OFF is reached, then an UP starts on the next sampled edge.
- STEP_CYC=1: one segment transition per cycle, and all timing formulas still hold.
- NSEG=1: UP lasts STEP_CYC cycles, then ON.
- cnt never wraps; it is cleared on every segment transition.

Test Plan:
- Reset: RN=0 with PWR_REQ=1 -> SW_EN=0000, ISO_EN=1, PWR_ACK=0, BUSY=0; after release, UP starts on the first edge.
- Power-up (defaults): PWR_REQ rises, sampled at E0 -> SW_EN=0001@E0, 0011@E0+8, 0111@E0+16, 1111@E0+24; PWR_ACK=1 and ISO_EN=0 @E0+32; BUSY low @E0+32.
- Power-down: from ON, PWR_REQ=0 sampled at D0 -> PWR_ACK=0 and ISO_EN=1 @D0; SW_EN=0111@D0+1, 0011@D0+9, 0001@D0+17, 0000@D0+25; BUSY=0 @D0+33.
- Abort in UP: PWR_REQ drops when SW_EN=0011 -> SW_EN=0001 same edge, 0000 after 8 more cycles, OFF 8 cycles later; PWR_ACK never 1.
- Re-request in DOWN: PWR_REQ=1 at D0+5 -> down sequence completes unchanged, then SW_EN=0001 one cycle after OFF.
- Async reset mid-ramp at SW_EN=0111 -> all outputs reach reset values immediately without a clock edge; monitor thermometer invariant and ACK-implies-all-on throughout.
